// File: rtl/uart_led_cmd.sv
// uart_led_cmd: ASCII command parser sitting between UART_RX and UART_TX.
//
// Accepts "R0/R1/G0/G1/B0/B1" followed by CR or LF to set an LED, and "?"
// followed by CR or LF to query all three LEDs. Each command is answered over
// the UART_TX byte handshake with "OK\r\n", "ER\r\n" or "<r><g><b>\r\n".
//
// Ports:
//   i_Clock      system clock
//   i_Reset      synchronous active-high reset
//   i_RX_DV      one-cycle strobe, i_RX_Byte valid
//   i_RX_Byte    received byte
//   o_TX_DV      one-cycle strobe to UART_TX, o_TX_Byte valid
//   o_TX_Byte    byte to transmit, held until i_TX_Done
//   i_TX_Active  UART_TX busy
//   i_TX_Done    one-cycle pulse, UART_TX finished a byte
//   o_LED_R/G/B  LED drives (polarity from LED_ACTIVE_LOW)
//   o_Busy       a reply is pending or being sent
//   o_Overrun    sticky: a non-terminator byte was dropped during a reply
//   o_Cmd_Count  number of valid commands executed (wraps)
`timescale 1ns/1ps

module uart_led_cmd #(
    parameter int CNT_W          = 8,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_RX_DV,
    input  logic [7:0]       i_RX_Byte,
    output logic             o_TX_DV,
    output logic [7:0]       o_TX_Byte,
    input  logic             i_TX_Active,
    input  logic             i_TX_Done,
    output logic             o_LED_R,
    output logic             o_LED_G,
    output logic             o_LED_B,
    output logic             o_Busy,
    output logic             o_Overrun,
    output logic [CNT_W-1:0] o_Cmd_Count
);

    typedef enum logic [2:0] {
        S_IDLE, S_GOT_CMD, S_GOT_ARG, S_DISCARD, S_RESP, S_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {RPL_OK, RPL_ER, RPL_QRY} reply_t;

    // Latched command letter; the R/G/B codes double as the LED bit index.
    localparam logic [1:0] CMD_R = 2'd0;
    localparam logic [1:0] CMD_G = 2'd1;
    localparam logic [1:0] CMD_B = 2'd2;
    localparam logic [1:0] CMD_Q = 2'd3;

    localparam logic LED_POL = (LED_ACTIVE_LOW != 0);

    state_t             state_q, state_d;
    reply_t             reply_q, reply_d;
    logic [1:0]         cmd_q, cmd_d;
    logic               arg_q, arg_d;
    logic [2:0]         led_q, led_d;     // logical on-state, bit0=R bit1=G bit2=B
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               overrun_q, overrun_d;
    logic [2:0]         idx_q, idx_d;
    logic               tx_dv_q, tx_dv_d;
    logic [7:0]         tx_byte_q, tx_byte_d;

    logic               is_term;
    logic               busy;
    logic [7:0]         reply_byte;
    logic [2:0]         reply_last;
    logic [2:0]         led_drive;

    assign is_term = (i_RX_Byte == 8'h0D) || (i_RX_Byte == 8'h0A);
    assign busy    = (state_q == S_RESP) || (state_q == S_WAIT_DONE);

    // Reply byte selected by the current index. LEDs cannot change while a
    // reply is in progress, so the query digits are read live.
    always_comb begin
        reply_byte = 8'h0A;
        reply_last = (reply_q == RPL_QRY) ? 3'd4 : 3'd3;
        case (idx_q)
            3'd0: begin
                case (reply_q)
                    RPL_OK:  reply_byte = 8'h4F;               // 'O'
                    RPL_ER:  reply_byte = 8'h45;               // 'E'
                    default: reply_byte = {7'h18, led_q[0]};   // '0'/'1'
                endcase
            end
            3'd1: begin
                case (reply_q)
                    RPL_OK:  reply_byte = 8'h4B;               // 'K'
                    RPL_ER:  reply_byte = 8'h52;               // 'R'
                    default: reply_byte = {7'h18, led_q[1]};
                endcase
            end
            3'd2:    reply_byte = (reply_q == RPL_QRY) ? {7'h18, led_q[2]} : 8'h0D;
            3'd3:    reply_byte = (reply_q == RPL_QRY) ? 8'h0D : 8'h0A;
            default: reply_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        reply_d   = reply_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        led_d     = led_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        idx_d     = idx_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;

        case (state_q)
            S_IDLE: begin
                if (i_RX_DV && !is_term) begin
                    state_d = S_GOT_CMD;
                    case (i_RX_Byte)
                        8'h52:   cmd_d = CMD_R;
                        8'h47:   cmd_d = CMD_G;
                        8'h42:   cmd_d = CMD_B;
                        8'h3F:   cmd_d = CMD_Q;
                        default: state_d = S_DISCARD;
                    endcase
                end
            end
            S_GOT_CMD: begin
                if (i_RX_DV) begin
                    if (cmd_q == CMD_Q) begin
                        if (is_term) begin
                            state_d = S_RESP;
                            reply_d = RPL_QRY;
                            idx_d   = 3'd0;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            state_d = S_DISCARD;
                        end
                    end else if (i_RX_Byte == 8'h30 || i_RX_Byte == 8'h31) begin
                        arg_d   = i_RX_Byte[0];
                        state_d = S_GOT_ARG;
                    end else if (is_term) begin
                        // Letter without digit: the terminator ends it here.
                        state_d = S_RESP;
                        reply_d = RPL_ER;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
            end
            S_GOT_ARG: begin
                if (i_RX_DV) begin
                    if (is_term) begin
                        case (cmd_q)
                            CMD_R:   led_d[0] = arg_q;
                            CMD_G:   led_d[1] = arg_q;
                            default: led_d[2] = arg_q;
                        endcase
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_RESP;
                        reply_d = RPL_OK;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if (i_RX_DV && is_term) begin
                    state_d = S_RESP;
                    reply_d = RPL_ER;
                    idx_d   = 3'd0;
                end
            end
            S_RESP: begin
                if (!i_TX_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = reply_byte;
                    state_d   = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_TX_Done) begin
                    if (idx_q == reply_last) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_RESP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bytes received during a reply are never parsed; terminators are
        // harmless (e.g. the LF of a CRLF), anything else is an overrun.
        if (busy && i_RX_DV && !is_term) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            reply_q   <= RPL_OK;
            cmd_q     <= CMD_R;
            arg_q     <= 1'b0;
            led_q     <= 3'b000;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            idx_q     <= 3'd0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            reply_q   <= reply_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            led_q     <= led_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            idx_q     <= idx_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_led
            assign led_drive[gi] = led_q[gi] ^ LED_POL;
        end
    endgenerate

    assign o_LED_R     = led_drive[0];
    assign o_LED_G     = led_drive[1];
    assign o_LED_B     = led_drive[2];
    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Busy      = busy;
    assign o_Overrun   = overrun_q;
    assign o_Cmd_Count = cnt_q;

endmodule
